// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_pkg
// Purpose  : Shared types, default parameter values and helpers for the
//            SYNC-framed serial DAC transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package dac_pkg;

  // Default parameter values used by dac_frame_tx and its divider
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CMD_W   = 8;
  localparam int DEF_CH      = 2;
  localparam int DEF_CLK_DIV = 1;
  localparam int DEF_GAP_CYC = 2;

  // Transmitter sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Bits per serial frame: command word followed by data word
  function automatic int frame_w(input int cmd_w, input int data_w);
    return cmd_w + data_w;
  endfunction

endpackage : dac_pkg
`default_nettype wire

// File: rtl/dac_sclk_div.sv
`default_nettype none
// ============================================================================
// Module   : dac_sclk_div
// Purpose  : SCLK half-period divider. Counts CLK_DIV clk cycles per half
//            period, emits a one-cycle tick at each half-period boundary and
//            flags whether that boundary is a rising SCLK transition.
// Revision : 1.0 - initial release
// ============================================================================
module dac_sclk_div
  import dac_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick,
  output logic rise,
  output logic level
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             w_tick;

  // A boundary is reached on the last cycle of each half period
  assign w_tick = en && !clear && (r_cnt == C_CNT_LAST);

  // Half-period counter and SCLK level; clear restarts a frame with SCLK high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else if (clear) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else if (en) begin
      if (w_tick) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign tick  = w_tick;
  assign rise  = w_tick && !r_level;
  assign level = r_level;

endmodule : dac_sclk_div
`default_nettype wire

// File: rtl/dac_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : dac_frame_tx
// Purpose  : Accepts one multi-channel sample vector and serialises one
//            {command, data} frame per enabled channel, MSB first, with a
//            gated SCLK, per-frame active-low SYNC and a configurable gap.
// Revision : 1.0 - initial release
// ============================================================================
module dac_frame_tx
  import dac_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CMD_W   = DEF_CMD_W,
  parameter int CH      = DEF_CH,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [CH*DATA_W-1:0] sample_data,
  input  logic [CH*CMD_W-1:0]  cmd_word,
  input  logic [CH-1:0]        ch_en,
  output logic                busy,
  output logic                done,
  output logic                sclk,
  output logic                sync,
  output logic                din
);

  localparam int FRAME_W = frame_w(CMD_W, DATA_W);
  localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1;
  localparam int BIT_W   = $clog2(FRAME_W + 1);
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(FRAME_W);
  localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(GAP_CYC - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CH*DATA_W-1:0] r_data;
  logic [CH*CMD_W-1:0]  r_cmd;
  logic [CH-1:0]        r_en;
  logic [FRAME_W-1:0]   r_shreg;
  logic [CH_W-1:0]      r_ch;
  logic [BIT_W-1:0]     r_bitcnt;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_sync;

  logic                 w_hs;
  logic                 w_start;
  logic                 w_shift_en;
  logic                 w_tick;
  logic                 w_rise;
  logic                 w_level;
  logic                 w_first_found;
  logic                 w_next_found;
  logic [CH_W-1:0]      w_first_idx;
  logic [CH_W-1:0]      w_next_idx;
  logic [CH_W-1:0]      w_load_idx;
  logic [FRAME_W-1:0]   w_load_word;

  assign w_hs       = sample_valid && r_ready;
  assign w_shift_en = (r_state == SHIFT);

  dac_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_start),
    .en    (w_shift_en),
    .tick  (w_tick),
    .rise  (w_rise),
    .level (w_level)
  );

  // Priority find: lowest enabled channel of a new vector, and lowest
  // latched-enabled channel above the one just sent
  always_comb begin
    w_first_found = 1'b0;
    w_first_idx   = '0;
    w_next_found  = 1'b0;
    w_next_idx    = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (ch_en[i]) begin
        w_first_found = 1'b1;
        w_first_idx   = CH_W'(i);
      end
      if (r_en[i] && (CH_W'(i) > r_ch)) begin
        w_next_found = 1'b1;
        w_next_idx   = CH_W'(i);
      end
    end
  end

  // Frame word for the channel being started: live inputs on the handshake,
  // the latched vector for later channels
  always_comb begin
    if (r_state == IDLE) begin
      w_load_idx  = w_first_idx;
      w_load_word = {cmd_word[w_first_idx*CMD_W +: CMD_W],
                     sample_data[w_first_idx*DATA_W +: DATA_W]};
    end else begin
      w_load_idx  = w_next_idx;
      w_load_word = {r_cmd[w_next_idx*CMD_W +: CMD_W],
                     r_data[w_next_idx*DATA_W +: DATA_W]};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; w_start marks the cycle a frame is loaded
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          if (w_first_found) begin
            w_state_nxt = SHIFT;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = FIN;
          end
        end
      end
      SHIFT: begin
        // The rising boundary after the last falling edge closes the frame
        if (w_rise && (r_bitcnt == C_BIT_LAST)) w_state_nxt = GAP;
      end
      GAP: begin
        if (r_gap_cnt == C_GAP_LAST) begin
          if (w_next_found) begin
            w_state_nxt = SHIFT;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = FIN;
          end
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Vector latch, shift register, channel index, bit and gap counters.
  // The shift register shifts on every rising boundary including the one
  // that closes the frame, so it is all-zero (din low) once the frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_cmd     <= '0;
      r_en      <= '0;
      r_shreg   <= '0;
      r_ch      <= '0;
      r_bitcnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (w_hs) begin
        r_data <= sample_data;
        r_cmd  <= cmd_word;
        r_en   <= ch_en;
      end
      if (w_start) begin
        r_shreg  <= w_load_word;
        r_ch     <= w_load_idx;
        r_bitcnt <= '0;
      end else if (w_shift_en && w_tick) begin
        if (w_rise) r_shreg  <= {r_shreg[FRAME_W-2:0], 1'b0};
        else        r_bitcnt <= r_bitcnt + 1'b1;
      end
      r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 1'b1 : '0;
    end
  end

  // Registered status and SYNC, updated together with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sync  <= 1'b1;
    end else begin
      r_ready <= (w_state_nxt == IDLE);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == FIN);
      r_sync  <= (w_state_nxt != SHIFT);
    end
  end

  assign sample_ready = r_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign sync         = r_sync;
  assign sclk         = w_level;
  assign din          = r_shreg[FRAME_W-1];

endmodule : dac_frame_tx
`default_nettype wire

// File: tb/tb_dac_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_frame_tx
// Purpose  : Self-checking bench for dac_frame_tx. Two instances (CLK_DIV=1
//            and CLK_DIV=3) share the data inputs; each vector's SYNC/SCLK/
//            DIN waveform is decoded and compared with frame timing and
//            contents computed from the transfer rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_frame_tx;

  localparam int F   = 16;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid1 = 1'b0;
  logic        valid3 = 1'b0;
  logic [15:0] sample_data = '0;
  logic [15:0] cmd_word = '0;
  logic [1:0]  ch_en = '0;

  logic ready1, busy1, done1, sclk1, sync1, din1;
  logic ready3, busy3, done3, sclk3, sync3, din3;
  logic m_ready, m_busy, m_done, m_sclk, m_sync, m_din;
  bit   sel = 1'b0;

  int checks = 0;
  int errors = 0;
  int w = 0;

  dac_frame_tx #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sample_valid(valid1), .sample_ready(ready1),
    .sample_data(sample_data), .cmd_word(cmd_word), .ch_en(ch_en),
    .busy(busy1), .done(done1), .sclk(sclk1), .sync(sync1), .din(din1)
  );

  dac_frame_tx #(.CLK_DIV(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .sample_valid(valid3), .sample_ready(ready3),
    .sample_data(sample_data), .cmd_word(cmd_word), .ch_en(ch_en),
    .busy(busy3), .done(done3), .sclk(sclk3), .sync(sync3), .din(din3)
  );

  assign m_ready = sel ? ready3 : ready1;
  assign m_busy  = sel ? busy3  : busy1;
  assign m_done  = sel ? done3  : done1;
  assign m_sclk  = sel ? sclk3  : sclk1;
  assign m_sync  = sel ? sync3  : sync1;
  assign m_din   = sel ? din3   : din1;

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one vector to the selected instance, decode its pin activity until
  // sample_ready returns, and compare against the expected frame schedule.
  // Sample index r=1 is the negedge right after the handshake edge.
  task automatic send_vec(input logic [15:0] data, input logic [15:0] cmd,
                          input logic [1:0] en, input bit hold,
                          input bit mutate, output int waited);
    logic [15:0] exp_w[$];
    logic [15:0] word_q[$];
    int          fall_q[$];
    int          rise_q[$];
    logic [15:0] cur;
    int d, p, e;
    int ready_r, done_r, ndone, nfall, first_fall, sclk_bad, busy_bad, high_run;
    logic prev_sync, prev_sclk;

    d = sel ? 3 : 1;
    p = 2 * F * d + GAP;
    for (int c = 0; c < 2; c++)
      if (en[c]) exp_w.push_back({cmd[c*8 +: 8], data[c*8 +: 8]});
    e = exp_w.size();

    sample_data = data;
    cmd_word    = cmd;
    ch_en       = en;
    if (sel) valid3 = 1'b1; else valid1 = 1'b1;

    waited = 0;
    while (m_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (m_ready !== 1'b1) begin
      check("handshake_timeout", 0, 1);
      valid1 = 1'b0;
      valid3 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      valid1 = 1'b0;
      valid3 = 1'b0;
    end

    cur = '0; ready_r = -1; done_r = -1; ndone = 0; nfall = 0;
    first_fall = -1; sclk_bad = 0; busy_bad = 0; high_run = 0;
    prev_sync = 1'b1; prev_sclk = 1'b1;
    for (int r = 1; r <= 400; r++) begin
      @(negedge clk);
      if (mutate && r == 5) begin
        sample_data = 16'($urandom);
        cmd_word    = 16'($urandom);
        ch_en       = 2'($urandom);
      end
      if (prev_sync && !m_sync) begin
        fall_q.push_back(r);
        cur = '0;
      end
      if (prev_sclk && !m_sclk) begin
        cur = {cur[14:0], m_din};
        nfall++;
        if (first_fall < 0) first_fall = r;
      end
      if (!prev_sync && m_sync) begin
        rise_q.push_back(r);
        word_q.push_back(cur);
      end
      if (m_sync && !m_sclk) sclk_bad++;
      if (m_busy === m_ready) busy_bad++;
      if (m_done) begin
        ndone++;
        done_r = r;
      end
      high_run  = m_sync ? high_run + 1 : 0;
      prev_sync = m_sync;
      prev_sclk = m_sclk;
      if (m_ready) begin
        ready_r = r;
        break;
      end
    end

    check("ready_at", ready_r, 2 + e * p);
    check("done_pulses", ndone, 1);
    check("done_at", done_r, 1 + e * p);
    check("sync_frames", fall_q.size(), e);
    check("sync_rises", rise_q.size(), e);
    for (int n = 0; n < e; n++) begin
      if (n < fall_q.size())
        check($sformatf("sync_fall_%0d", n), fall_q[n], 1 + n * p);
      if (n < rise_q.size()) begin
        check($sformatf("sync_rise_%0d", n), rise_q[n], 1 + n * p + 2 * F * d);
        check($sformatf("frame_word_%0d", n), int'(word_q[n]), int'(exp_w[n]));
      end
    end
    check("sclk_falls", nfall, e * F);
    if (e > 0) check("first_sclk_fall", first_fall, 1 + d);
    check("sclk_low_outside_sync", sclk_bad, 0);
    check("busy_not_ready", busy_bad, 0);
    check("sync_high_tail", high_run, (e > 0) ? GAP + 2 : 2);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready1", int'(ready1), 1);
    check("rst_busy1",  int'(busy1),  0);
    check("rst_done1",  int'(done1),  0);
    check("rst_sclk1",  int'(sclk1),  1);
    check("rst_sync1",  int'(sync1),  1);
    check("rst_din1",   int'(din1),   0);
    check("rst_ready3", int'(ready3), 1);
    check("rst_sclk3",  int'(sclk3),  1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single channel, defaults: frame 0x40A5
    sel = 1'b0;
    send_vec(16'h00A5, 16'h0040, 2'b01, 1'b0, 1'b0, w);
    // Both channels: second frame 0x413C
    send_vec(16'h3CA5, 16'h4140, 2'b11, 1'b0, 1'b0, w);
    // Only channel 1 enabled
    send_vec(16'h5A00, 16'h7F00, 2'b10, 1'b0, 1'b0, w);
    // No channels enabled
    send_vec(16'hFFFF, 16'hFFFF, 2'b00, 1'b0, 1'b0, w);

    // Divided SCLK
    sel = 1'b1;
    send_vec(16'h00A5, 16'h0040, 2'b01, 1'b0, 1'b0, w);
    send_vec(16'h1234, 16'h8001, 2'b11, 1'b0, 1'b0, w);
    send_vec(16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, w);

    // Held valid with inputs changed mid-frame, then back-to-back vector
    sel = 1'b0;
    send_vec(16'hC3E1, 16'h2A55, 2'b11, 1'b1, 1'b1, w);
    send_vec(16'h0F96, 16'h81FF, 2'b01, 1'b0, 1'b0, w);
    check("b2b_handshake_wait", w, 0);

    // Asynchronous reset in the middle of a frame
    sample_data = 16'h00A5;
    cmd_word    = 16'h0040;
    ch_en       = 2'b01;
    valid1      = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_reset_sync", int'(sync1), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sync",  int'(sync1),  1);
    check("arst_sclk",  int'(sclk1),  1);
    check("arst_din",   int'(din1),   0);
    check("arst_ready", int'(ready1), 1);
    check("arst_busy",  int'(busy1),  0);
    check("arst_done",  int'(done1),  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_vec(16'h00A5, 16'h0040, 2'b01, 1'b0, 1'b0, w);

    // Randomized vectors on both instances
    for (int i = 0; i < 6; i++) begin
      sel = i[0];
      send_vec(16'($urandom), 16'($urandom), 2'($urandom), 1'b0, 1'b0, w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dac_frame_tx
`default_nettype wire
